// File: rtl/fib_seq.sv
// rtl/fib_seq.sv - Fibonacci / Lucas sequence term generator with req/ack handshake
//
// Computes S(n) of the Fibonacci (mode=0: S0=0, S1=1) or Lucas (mode=1: S0=2, S1=1)
// sequence by iterating a <= b, b <= a + b once per clock, modulo 2^N_OUT, and
// reports whether the true term exceeds the result width.
//
// Optional feature macro: FIB_SEQ_STREAM_EN
//   defined   : every CALC cycle presents term_valid=1, term=S(k), k = 0..n in order.
//   undefined : term_valid and term are constant 0 and no streaming logic is built.
//
// Ports:
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   req        in   1      request level, four-phase handshake with ack
//   n          in   N_IN   term index, sampled on accept
//   mode       in   1      0 = Fibonacci, 1 = Lucas, sampled on accept
//   ack        out  1      result valid, held until req is seen low
//   result     out  N_OUT  S(n) mod 2^N_OUT
//   ovf        out  1      S(n) >= 2^N_OUT
//   busy       out  1      high while computing or holding a result
//   term_valid out  1      streaming strobe
//   term       out  N_OUT  streaming term value
module fib_seq #(
  parameter int N_IN  = 7,
  parameter int N_OUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [N_IN-1:0]  n,
  input  logic             mode,
  output logic             ack,
  output logic [N_OUT-1:0] result,
  output logic             ovf,
  output logic             busy,
  output logic             term_valid,
  output logic [N_OUT-1:0] term
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N_OUT-1:0] FIB_S0 = '0;
  localparam logic [N_OUT-1:0] LUC_S0 = N_OUT'(2);
  localparam logic [N_OUT-1:0] SEQ_S1 = N_OUT'(1);

  state_t           state, state_nx;
  logic [N_IN-1:0]  cnt, cnt_nx;
  logic [N_OUT-1:0] a, a_nx;
  logic [N_OUT-1:0] b, b_nx;
  // a_ovf / b_ovf record whether the true (unwrapped) value of a / b has
  // reached 2^N_OUT. They are tracked per register so that ovf reflects only
  // the delivered term a, even when the look-ahead term b has already wrapped.
  logic             a_ovf, a_ovf_nx;
  logic             b_ovf, b_ovf_nx;
  logic [N_OUT-1:0] result_nx;
  logic             ovf_nx;
  logic             ack_nx;
  logic [N_OUT:0]   sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    a_nx      = a;
    b_nx      = b;
    a_ovf_nx  = a_ovf;
    b_ovf_nx  = b_ovf;
    result_nx = result;
    ovf_nx    = ovf;
    ack_nx    = ack;

    case (state)
      IDLE: begin
        if (req) begin
          state_nx = CALC;
          cnt_nx   = n;
          a_nx     = mode ? LUC_S0 : FIB_S0;
          b_nx     = SEQ_S1;
          a_ovf_nx = 1'b0;
          b_ovf_nx = 1'b0;
        end
      end

      CALC: begin
        if (!req) begin
          // Abort: drop the computation, leave the last result untouched.
          state_nx = IDLE;
        end else if (cnt != '0) begin
          cnt_nx   = cnt - N_IN'(1);
          a_nx     = b;
          b_nx     = sum[N_OUT-1:0];
          a_ovf_nx = b_ovf;
          // Once either addend has wrapped, every later term is larger still.
          b_ovf_nx = sum[N_OUT] | a_ovf | b_ovf;
        end else begin
          state_nx  = DONE;
          result_nx = a;
          ovf_nx    = a_ovf;
          ack_nx    = 1'b1;
        end
      end

      DONE: begin
        // Leaving DONE requires req low, so a held req cannot re-trigger in IDLE.
        if (!req) begin
          state_nx = IDLE;
          ack_nx   = 1'b0;
        end
      end

      default: begin
        state_nx = IDLE;
        ack_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a      <= '0;
      b      <= '0;
      a_ovf  <= 1'b0;
      b_ovf  <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      ack    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      a      <= a_nx;
      b      <= b_nx;
      a_ovf  <= a_ovf_nx;
      b_ovf  <= b_ovf_nx;
      result <= result_nx;
      ovf    <= ovf_nx;
      ack    <= ack_nx;
      busy   <= (state_nx != IDLE);
    end
  end

`ifdef FIB_SEQ_STREAM_EN
  // Registered from next-state values so that term_valid is exactly
  // (state == CALC) and term is exactly a during every CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_valid <= 1'b0;
      term       <= '0;
    end else begin
      term_valid <= (state_nx == CALC);
      if (state_nx == CALC) begin
        term <= a_nx;
      end
    end
  end
`else
  assign term_valid = 1'b0;
  assign term       = '0;
`endif

endmodule

// File: tb/tb_fib_seq.sv
// tb/tb_fib_seq.sv - self-checking bench for fib_seq
module tb_fib_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req   = 1'b0;
  logic [6:0]  n     = '0;
  logic        mode  = 1'b0;
  logic        ack;
  logic [63:0] result;
  logic        ovf;
  logic        busy;
  logic        term_valid;
  logic [63:0] term;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] res;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] terms_got[$];

  fib_seq #(.N_IN(7), .N_OUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .n          (n),
    .mode       (mode),
    .ack        (ack),
    .result     (result),
    .ovf        (ovf),
    .busy       (busy),
    .term_valid (term_valid),
    .term       (term)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] seq_term(input int k, input logic m);
    logic [127:0] sa, sb_, t;
    sa  = m ? 128'd2 : 128'd0;
    sb_ = 128'd1;
    for (int i = 0; i < k; i++) begin
      t   = sa + sb_;
      sa  = sb_;
      sb_ = t;
    end
    return sa;
  endfunction

  task automatic sample_term();
    if (term_valid === 1'b1) terms_got.push_back(term);
  endtask

  // One complete handshake. use_k selects the caller's constant expectation
  // instead of the bench model; rel_rst releases reset on the drive edge.
  task automatic run_req(input string tag, input int nv, input logic mv, input int hold,
                         input logic use_k, input logic [63:0] kres, input logic kovf,
                         input logic rel_rst);
    logic [127:0] full;
    exp_t e;
    int cyc;
    @(negedge clk);
    if (rel_rst) rst_n = 1'b1;
    req  = 1'b1;
    n    = nv[6:0];
    mode = mv;
    terms_got.delete();
    @(posedge clk);
    full = seq_term(nv, mv);
    if (use_k) sb.push_back({kres, kovf});
    else       sb.push_back({full[63:0], |full[127:64]});
    #1;
    sample_term();
    checks++;
    if (busy !== 1'b1 || ack !== 1'b0)
      $display("FAIL %s accept: busy=%b ack=%b required busy=1 ack=0", tag, busy, ack);
    @(negedge clk);
    n    = ~n;
    mode = ~mode;
    cyc  = 0;
    do begin
      @(posedge clk);
      cyc++;
      #1;
      sample_term();
    end while (ack !== 1'b1 && cyc < 300);
    checks++;
    if (cyc != nv + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d clocks required %0d", tag, cyc, nv + 1);
    end
    e = sb.pop_front();
    checks++;
    if (result !== e.res) begin
      errors++;
      $display("FAIL %s result: got %0d required %0d", tag, result, e.res);
    end
    checks++;
    if (ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s ovf: got %b required %b", tag, ovf, e.ovf);
    end
`ifdef FIB_SEQ_STREAM_EN
    checks++;
    if (terms_got.size() != nv + 1) begin
      errors++;
      $display("FAIL %s stream_count: got %0d required %0d", tag, terms_got.size(), nv + 1);
    end else begin
      for (int k = 0; k <= nv; k++) begin
        full = seq_term(k, mv);
        checks++;
        if (terms_got[k] !== full[63:0]) begin
          errors++;
          $display("FAIL %s stream_term[%0d]: got %0d required %0d", tag, k, terms_got[k], full[63:0]);
        end
      end
    end
`else
    checks++;
    if (terms_got.size() != 0) begin
      errors++;
      $display("FAIL %s stream_off: got %0d strobes required 0", tag, terms_got.size());
    end
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ack !== 1'b1 || busy !== 1'b1 || result !== e.res || ovf !== e.ovf) begin
        errors++;
        $display("FAIL %s hold: ack=%b busy=%b result=%0d ovf=%b required ack=1 busy=1 result=%0d ovf=%b",
                 tag, ack, busy, result, ovf, e.res, e.ovf);
      end
    end
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || result !== e.res || ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s release: ack=%b busy=%b result=%0d ovf=%b required ack=0 busy=0 result=%0d ovf=%b",
               tag, ack, busy, result, ovf, e.res, e.ovf);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0 || result !== 64'd0 ||
        term_valid !== 1'b0 || term !== 64'd0) begin
      errors++;
      $display("FAIL reset: ack=%b busy=%b ovf=%b result=%0d tv=%b term=%0d required all 0",
               ack, busy, ovf, result, term_valid, term);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b ack=%b required 0 0", busy, ack);
    end
  endtask

  task automatic test_known();
    run_req("fib66", 66, 1'b0, 3, 1'b1, 64'd27777890035288, 1'b0, 1'b0);
    run_req("fib93", 93, 1'b0, 1, 1'b1, 64'd12200160415121876738, 1'b0, 1'b0);
    run_req("fib94", 94, 1'b0, 1, 1'b1, 64'd1293530146158671551, 1'b1, 1'b0);
    run_req("luc10", 10, 1'b1, 0, 1'b1, 64'd123, 1'b0, 1'b0);
    run_req("luc0",  0,  1'b1, 1, 1'b1, 64'd2, 1'b0, 1'b0);
    run_req("fib0",  0,  1'b0, 0, 1'b1, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic test_stream();
    run_req("stream6", 6, 1'b0, 0, 1'b1, 64'd8, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_req("rand", int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), 1'b0, 64'd0, 1'b0, 1'b0);
    end
    run_req("fib127", 127, 1'b0, 0, 1'b0, 64'd0, 1'b0, 1'b0);
    run_req("luc127", 127, 1'b1, 0, 1'b0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    logic [63:0] r0;
    logic        o0;
    r0 = result;
    o0 = ovf;
    @(negedge clk);
    req  = 1'b1;
    n    = 7'd50;
    mode = 1'b0;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0 || result !== r0 || ovf !== o0) begin
      errors++;
      $display("FAIL abort: busy=%b ack=%b result=%0d ovf=%b required busy=0 ack=0 result=%0d ovf=%b",
               busy, ack, result, ovf, r0, o0);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: ack=%b busy=%b required 0 0", ack, busy);
    end
    run_req("after_abort", 5, 1'b0, 0, 1'b1, 64'd5, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req  = 1'b1;
    n    = 7'd66;
    mode = 1'b0;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_busy: got %b required 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0 || result !== 64'd0 ||
        term_valid !== 1'b0 || term !== 64'd0) begin
      errors++;
      $display("FAIL async_reset: ack=%b busy=%b ovf=%b result=%0d tv=%b term=%0d required all 0",
               ack, busy, ovf, result, term_valid, term);
    end
    repeat (2) @(posedge clk);
    run_req("post_reset", 66, 1'b0, 1, 1'b1, 64'd27777890035288, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_req("b2b_a", 12, 1'b0, 0, 1'b0, 64'd0, 1'b0, 1'b0);
    run_req("b2b_b", 3,  1'b1, 0, 1'b0, 64'd0, 1'b0, 1'b0);
    run_req("b2b_c", 1,  1'b0, 0, 1'b1, 64'd1, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_known();
    test_stream();
    test_abort();
    test_back_to_back();
    test_random();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
